// File: rtl/reg_file_pkg.sv
// Shared CPU package: default datapath widths and architectural constants
// used by the register file, ALU and decoder.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned WR_COUNT_W = 16;

    // True when a write request actually changes architectural state.
    function automatic logic is_commit(input logic we, input logic addr_is_zero);
        return we && !addr_is_zero;
    endfunction

endpackage : reg_file_pkg

// File: rtl/reg_read_port.sv
// One combinational read port of the register file.
// Ports:
//   rd_addr   - register index being read
//   rd_stored - array contents at rd_addr (selected by the parent)
//   we, wr_addr, wr_data - the write request of the current cycle
//   rd_data   - resolved read data (zero register forced, optional forwarding)
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic rd_is_zero_c;
    logic hit_c;

    // Register 0 wins over forwarding, so a write to r0 is never visible.
    always_comb begin
        rd_is_zero_c = (rd_addr == ADDR_W'(REG_ZERO));
        hit_c        = (BYPASS != 0) && we && (wr_addr == rd_addr);
        rd_data      = rd_stored;
        if (rd_is_zero_c) begin
            rd_data = '0;
        end else if (hit_c) begin
            rd_data = wr_data;
        end
    end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// Register file: 2**ADDR_W x DATA_W, one write port, three combinational
// read ports (op1, op2, debug), and a committed-write counter.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   we, wr_addr, wr_data - write request, commits at rising edge
//   rs_addr -> op1, rt_addr -> op2, dbg_addr -> dbg_data - read ports
//   wr_count          - number of committed writes, wraps at 16 bits
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [WR_COUNT_W-1:0] wr_count_q;
    logic [WR_COUNT_W-1:0] wr_count_d;
    logic                  commit_c;

    // Next-state: writes to r0 are dropped and do not count.
    always_comb begin
        commit_c   = is_commit(we, wr_addr == ADDR_W'(REG_ZERO));
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (commit_c) begin
            regs_d[wr_addr] = wr_data;
            wr_count_d      = wr_count_q + WR_COUNT_W'(1);
        end
    end

    // State: reset clears everything without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_op1 (
        .rd_addr   (rs_addr),
        .rd_stored (regs_q[rs_addr]),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data   (op1)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_op2 (
        .rd_addr   (rt_addr),
        .rd_stored (regs_q[rt_addr]),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data   (op2)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_dbg (
        .rd_addr   (dbg_addr),
        .rd_stored (regs_q[dbg_addr]),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_data   (dbg_data)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a forwarding instance and a
// non-forwarding instance share stimulus and are compared against an
// array-based reference model.
module tb_reg_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk;
    logic          rst;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] op1, op2, dbg_data;
    logic [DW-1:0] op1_nb, op2_nb, dbg_nb;
    logic [15:0]   wr_count, wr_count_nb;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and total committed writes.
    logic [DW-1:0] model [NR];
    int unsigned   model_cnt;

    reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .op1(op1), .op2(op2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
    );

    reg_file #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .op1(op1_nb), .op2(op2_nb),
        .dbg_addr(dbg_addr), .dbg_data(dbg_nb), .wr_count(wr_count_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < int'(NR); i++) model[i] = '0;
        model_cnt = 0;
    endfunction

    // Expected read value for a port, from the architectural rules.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we && wr_addr == a) return wr_data;
        if (rst) return '0;
        return model[a];
    endfunction

    function automatic logic [15:0] exp_cnt();
        return 16'(model_cnt % 65536);
    endfunction

    // Advance one clock edge, apply it to the model, settle past the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst && we && wr_addr != 0) begin
            model[wr_addr] = wr_data;
            model_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        model_clear();
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            rs_addr = AW'(i); rt_addr = AW'(i); dbg_addr = AW'(i);
            #1;
            checks++;
            if (op1 !== '0 || op2 !== '0 || dbg_data !== '0 ||
                op1_nb !== '0 || op2_nb !== '0 || dbg_nb !== '0) begin
                errors++;
                $display("FAIL reset_read idx=%0d: got %h %h %h / %h %h %h, exp all 0",
                         i, op1, op2, dbg_data, op1_nb, op2_nb, dbg_nb);
            end
        end
        checks++;
        if (wr_count !== 16'd0 || wr_count_nb !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d/%0d exp 0", wr_count, wr_count_nb);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        we = 1'b0; rs_addr = 5'd5; rt_addr = 5'd5;
        #1;
        checks++;
        if (op1 !== 32'hDEADBEEF || op2 !== 32'hDEADBEEF ||
            op1_nb !== 32'hDEADBEEF || op2_nb !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read r5: got %h %h %h %h exp deadbeef",
                     op1, op2, op1_nb, op2_nb);
        end
        checks++;
        if (wr_count !== 16'd1 || wr_count_nb !== 16'd1) begin
            errors++;
            $display("FAIL write_read_count: got %0d/%0d exp 1", wr_count, wr_count_nb);
        end
    endtask

    task automatic test_zero_write();
        logic [15:0] prev;
        prev = exp_cnt();
        we = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        #1;
        checks++;
        if (op1 !== '0 || op2 !== '0 || dbg_data !== '0) begin
            errors++;
            $display("FAIL zero_fwd: got %h %h %h exp 0", op1, op2, dbg_data);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (op1 !== '0 || op1_nb !== '0) begin
            errors++;
            $display("FAIL zero_read: got %h/%h exp 0", op1, op1_nb);
        end
        checks++;
        if (wr_count !== prev || wr_count_nb !== prev) begin
            errors++;
            $display("FAIL zero_count: got %0d/%0d exp %0d", wr_count, wr_count_nb, prev);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old_v;
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h0BAD0007;
        tick();
        old_v = 32'h0BAD0007;
        wr_data = 32'h12345678;
        rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
        #1;
        checks++;
        if (op1 !== 32'h12345678 || op2 !== 32'h12345678 || dbg_data !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_fwd: got %h %h %h exp 12345678", op1, op2, dbg_data);
        end
        checks++;
        if (op1_nb !== old_v || op2_nb !== old_v || dbg_nb !== old_v) begin
            errors++;
            $display("FAIL nobypass_before: got %h %h %h exp %h", op1_nb, op2_nb, dbg_nb, old_v);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (op1_nb !== 32'h12345678 || op1 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_after: got %h/%h exp 12345678", op1, op1_nb);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we       = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, NR - 1));
            wr_data  = $urandom;
            rs_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
            rt_addr  = ($urandom_range(0, 3) == 0) ? rs_addr : AW'($urandom_range(0, NR - 1));
            dbg_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR - 1));
            #1;
            checks++;
            if (op1 !== exp_rd(rs_addr, 1) || op2 !== exp_rd(rt_addr, 1) ||
                dbg_data !== exp_rd(dbg_addr, 1)) begin
                errors++;
                $display("FAIL rand_byp n=%0d: got %h %h %h exp %h %h %h", n, op1, op2, dbg_data,
                         exp_rd(rs_addr, 1), exp_rd(rt_addr, 1), exp_rd(dbg_addr, 1));
            end
            checks++;
            if (op1_nb !== exp_rd(rs_addr, 0) || op2_nb !== exp_rd(rt_addr, 0) ||
                dbg_nb !== exp_rd(dbg_addr, 0)) begin
                errors++;
                $display("FAIL rand_nobyp n=%0d: got %h %h %h exp %h %h %h", n, op1_nb, op2_nb,
                         dbg_nb, exp_rd(rs_addr, 0), exp_rd(rt_addr, 0), exp_rd(dbg_addr, 0));
            end
            checks++;
            if (wr_count !== exp_cnt() || wr_count_nb !== exp_cnt()) begin
                errors++;
                $display("FAIL rand_count n=%0d: got %0d/%0d exp %0d", n, wr_count,
                         wr_count_nb, exp_cnt());
            end
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_reset_mid();
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        tick();
        we = 1'b0; rs_addr = 5'd3; rt_addr = 5'd9; dbg_addr = 5'd3;
        #1;
        checks++;
        if (op1 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL pre_reset r3: got %h exp a5a5a5a5", op1);
        end
        // Reset asserted between edges must act at once.
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (op1 !== '0 || dbg_data !== '0 || op1_nb !== '0 || wr_count !== 16'd0 ||
            wr_count_nb !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: got %h %h %h cnt %0d/%0d exp 0",
                     op1, dbg_data, op1_nb, wr_count, wr_count_nb);
        end
        // Write during reset: forwarded on the bypass instance only, never stored.
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h11112222;
        #1;
        checks++;
        if (op2 !== 32'h11112222 || op2_nb !== '0) begin
            errors++;
            $display("FAIL reset_fwd: got %h/%h exp 11112222/0", op2, op2_nb);
        end
        tick();
        rst = 1'b0;
        wr_data = 32'h33334444;
        #1;
        checks++;
        if (op2_nb !== '0 || wr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_edge_write: got %h cnt %0d exp 0 cnt 0", op2_nb, wr_count);
        end
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (op2 !== 32'h33334444 || op2_nb !== 32'h33334444 || wr_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_write: got %h/%h cnt %0d exp 33334444 cnt 1",
                     op2, op2_nb, wr_count);
        end
        checks++;
        if (op1 !== '0) begin
            errors++;
            $display("FAIL reset_lost_r3: got %h exp 0", op1);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1; we = 1'b0;
        model_clear();
        #1;
        rst = 1'b0;
        we = 1'b1;
        for (int n = 0; n < 65536; n++) begin
            wr_addr = AW'($urandom_range(1, NR - 1));
            wr_data = $urandom;
            tick();
        end
        we = 1'b0;
        #1;
        checks++;
        if (wr_count !== 16'd0 || wr_count_nb !== 16'd0) begin
            errors++;
            $display("FAIL wrap_zero: got %0d/%0d exp 0", wr_count, wr_count_nb);
        end
        rs_addr = AW'($urandom_range(1, NR - 1));
        #1;
        checks++;
        if (op1 !== model[rs_addr] || op1_nb !== model[rs_addr]) begin
            errors++;
            $display("FAIL wrap_data r%0d: got %h/%h exp %h", rs_addr, op1, op1_nb, model[rs_addr]);
        end
        we = 1'b1; wr_addr = 5'd1; wr_data = 32'h0;
        tick();
        we = 1'b0;
        #1;
        checks++;
        if (wr_count !== 16'd1 || wr_count_nb !== 16'd1) begin
            errors++;
            $display("FAIL wrap_one: got %0d/%0d exp 1", wr_count, wr_count_nb);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_write();
        test_bypass();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_file
